// File: rtl/mux_gate_alu_pkg.sv
// Shared constants for the mux-built bitwise ALU: op width and op codes.
package mux_gate_alu_pkg;

  localparam int OP_W = 3;

  // Function select codes; all eight values are legal.
  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

endpackage

// File: rtl/mux_gate_cell.sv
// 1-bit 2:1 multiplexer: the only primitive used to build the ALU datapath.
module mux_gate_cell (
  input  logic [1:0] in,
  input  logic       sel,
  output logic       out
);

  assign out = sel ? in[1] : in[0];

endmodule

// File: rtl/mux_gate_alu.sv
// Registered bitwise ALU built from 2:1 mux cells, with valid/ready
// handshakes and a main + skid output buffer for full-rate backpressure.
module mux_gate_alu
  import mux_gate_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OP_W-1:0]    in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [OP_W-1:0]    out_op,
  output logic [COUNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0] result;

  // Per-bit gate functions and the 8:1 op-select tree, all from mux cells.
  // Each gate uses operand a as the select and routes b, ~b or a constant.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_a, bit_b, bit_nb, bit_na;
      logic f_and, f_or, f_xor, f_nand, f_nor, f_xnor;
      logic l0_0, l0_1, l0_2, l0_3, l1_0, l1_1, bit_res;

      assign bit_a = in_a[gi];
      assign bit_b = in_b[gi];

      // Inverters: sel=x picks 0 when x=1, 1 when x=0.
      mux_gate_cell u_not_b (.in({1'b0, 1'b1}), .sel(bit_b), .out(bit_nb));
      mux_gate_cell u_not_a (.in({1'b0, 1'b1}), .sel(bit_a), .out(bit_na));

      mux_gate_cell u_and  (.in({bit_b,  1'b0  }), .sel(bit_a), .out(f_and));
      mux_gate_cell u_or   (.in({1'b1,   bit_b }), .sel(bit_a), .out(f_or));
      mux_gate_cell u_xor  (.in({bit_nb, bit_b }), .sel(bit_a), .out(f_xor));
      mux_gate_cell u_nand (.in({bit_nb, 1'b1  }), .sel(bit_a), .out(f_nand));
      mux_gate_cell u_nor  (.in({1'b0,   bit_nb}), .sel(bit_a), .out(f_nor));
      mux_gate_cell u_xnor (.in({bit_b,  bit_nb}), .sel(bit_a), .out(f_xnor));

      // Op tree: op[0] picks within pairs, op[1] within quads, op[2] halves.
      mux_gate_cell u_l0_0 (.in({f_or,   f_and }), .sel(in_op[0]), .out(l0_0));
      mux_gate_cell u_l0_1 (.in({f_nand, f_xor }), .sel(in_op[0]), .out(l0_1));
      mux_gate_cell u_l0_2 (.in({f_xnor, f_nor }), .sel(in_op[0]), .out(l0_2));
      mux_gate_cell u_l0_3 (.in({bit_na, bit_a }), .sel(in_op[0]), .out(l0_3));
      mux_gate_cell u_l1_0 (.in({l0_1,   l0_0  }), .sel(in_op[1]), .out(l1_0));
      mux_gate_cell u_l1_1 (.in({l0_3,   l0_2  }), .sel(in_op[1]), .out(l1_1));
      mux_gate_cell u_l2   (.in({l1_1,   l1_0  }), .sel(in_op[2]), .out(bit_res));

      assign result[gi] = bit_res;
    end
  endgenerate

  logic               main_valid_q, main_valid_d;
  logic [WIDTH-1:0]   main_data_q,  main_data_d;
  logic [OP_W-1:0]    main_op_q,    main_op_d;
  logic               skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]   skid_data_q,  skid_data_d;
  logic [OP_W-1:0]    skid_op_q,    skid_op_d;
  logic [COUNT_W-1:0] count_q,      count_d;
  logic               accept, drain, main_free;

  // in_ready depends only on skid occupancy, never on out_ready.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_q && out_ready;
  assign main_free = !main_valid_q || drain;

  // Buffer steering: skid has priority into main so order is preserved.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_op_d    = main_op_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_op_d    = skid_op_q;
    count_d      = count_q;

    if (drain) begin
      count_d = count_q + COUNT_W'(1);
    end

    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_op_d    = skid_op_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = result;
          skid_op_d   = in_op;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = result;
        main_op_d    = in_op;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = result;
      skid_op_d    = in_op;
    end
  end

  // State registers; reset discards any buffered results immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_op_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_op_q    <= '0;
      count_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_op_q    <= main_op_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_op_q    <= skid_op_d;
      count_q      <= count_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign out_op     = main_op_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_mux_gate_alu.sv
// Scoreboard bench for mux_gate_alu: an 8-bit instance and a 1-bit instance
// with a 2-bit transfer counter, checked against a plain-operator model.
module tb_mux_gate_alu;

  logic clk = 1'b0;
  logic rst_n;

  logic       v8, r8, ov8, ordy8;
  logic [7:0] a8, b8, od8, cnt8;
  logic [2:0] op8, oop8;

  logic       v1, r1, ov1, ordy1, a1, b1, od1;
  logic [2:0] op1, oop1;
  logic [1:0] cnt1;

  int errors = 0;
  int checks = 0;
  bit rnd8 = 0;
  bit rnd1 = 0;

  logic [10:0] exp8_q[$];
  logic [3:0]  exp1_q[$];
  logic [7:0]  exp_cnt8 = '0;
  logic [1:0]  exp_cnt1 = '0;
  bit          hold8 = 0, hold1 = 0;
  logic [7:0]  hold_d8;
  logic [2:0]  hold_op8, hold_op1;
  logic        hold_d1;

  mux_gate_alu #(.WIDTH(8), .COUNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8), .in_op(op8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_op(oop8),
    .xfer_count(cnt8)
  );

  mux_gate_alu #(.WIDTH(1), .COUNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_op(op1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_op(oop1),
    .xfer_count(cnt1)
  );

  always #5 clk = ~clk;

  // Reference: the eight bitwise functions written with ordinary operators.
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor/scoreboard for the 8-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      exp8_q.delete();
      exp_cnt8 <= '0;
      hold8    <= 0;
    end else begin
      chk("count8", cnt8, exp_cnt8);
      if (hold8) begin
        chk("hold_valid8", ov8, 1);
        chk("hold_data8", od8, hold_d8);
        chk("hold_op8", oop8, hold_op8);
      end
      if (ov8 && ordy8) begin
        if (exp8_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected8: got op=%0d data=%02h with empty scoreboard", oop8, od8);
        end else begin
          e = exp8_q.pop_front();
          $display("xfer8 op=%0d data=%02h", oop8, od8);
          chk("result8", {oop8, od8}, e);
        end
        exp_cnt8 <= exp_cnt8 + 8'd1;
      end
      hold8    <= ov8 && !ordy8;
      hold_d8  <= od8;
      hold_op8 <= oop8;
      if (v8 && r8) exp8_q.push_back({op8, ref_alu(op8, a8, b8)});
    end
  end

  // Monitor/scoreboard for the 1-bit instance.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [7:0] t;
    if (!rst_n) begin
      exp1_q.delete();
      exp_cnt1 <= '0;
      hold1    <= 0;
    end else begin
      chk("count1", cnt1, exp_cnt1);
      if (hold1) begin
        chk("hold_data1", od1, hold_d1);
        chk("hold_op1", oop1, hold_op1);
      end
      if (ov1 && ordy1) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected1: got op=%0d data=%0b with empty scoreboard", oop1, od1);
        end else begin
          e = exp1_q.pop_front();
          $display("xfer1 op=%0d data=%0b count=%0d", oop1, od1, cnt1);
          chk("result1", {oop1, od1}, e);
        end
        exp_cnt1 <= exp_cnt1 + 2'd1;
      end
      hold1    <= ov1 && !ordy1;
      hold_d1  <= od1;
      hold_op1 <= oop1;
      if (v1 && r1) begin
        t = ref_alu(op1, {7'd0, a1}, {7'd0, b1});
        exp1_q.push_back({op1, t[0]});
      end
    end
  end

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    if (rnd8) ordy8 = 1'($urandom_range(0, 1));
    while (!r8 && n < 50) begin
      @(posedge clk); #1;
      if (rnd8) ordy8 = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout8: in_ready stuck at %0b, required 1", r8);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic send1(input logic [2:0] op, input logic a, input logic b);
    int n = 0;
    v1 = 1'b1; op1 = op; a1 = a; b1 = b;
    if (rnd1) ordy1 = 1'($urandom_range(0, 1));
    while (!r1 && n < 50) begin
      @(posedge clk); #1;
      if (rnd1) ordy1 = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout1: in_ready stuck at %0b, required 1", r1);
    end
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    v8 = 1'b0; v1 = 1'b0; ordy8 = 1'b1; ordy1 = 1'b1;
    while ((exp8_q.size() != 0 || exp1_q.size() != 0 || ov8 || ov1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: pending8=%0d pending1=%0d, required 0", exp8_q.size(), exp1_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_t1 [8];
    exp_t1 = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'hCA, 8'h35};

    rst_n = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; op8 = 0; ordy8 = 1;
    v1 = 0; a1 = 0; b1 = 0; op1 = 0; ordy1 = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid8", ov8, 0);
    chk("reset_out_data8", od8, 0);
    chk("reset_out_op8", oop8, 0);
    chk("reset_count8", cnt8, 0);
    chk("reset_out_valid1", ov1, 0);
    chk("reset_count1", cnt1, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready8", r8, 1);
    chk("reset_in_ready1", r1, 1);

    // All eight ops back-to-back on CA/5C, each visible one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      send8(3'(i), 8'hCA, 8'h5C);
      chk("latency_valid8", ov8, 1);
      chk("table_data8", od8, exp_t1[i]);
      chk("table_op8", oop8, i);
      chk("throughput_ready8", r8, 1);
    end
    drain_all();
    chk("count_after_table8", cnt8, 8);

    // Backpressure: two beats fill main and skid, third is refused.
    ordy8 = 1'b0;
    send8(3'd0, 8'hFF, 8'h0F);
    send8(3'd1, 8'hF0, 8'h0F);
    chk("bp_in_ready_low8", r8, 0);
    v8 = 1'b1; op8 = 3'd2; a8 = 8'hAA; b8 = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready_held8", r8, 0);
    end
    // Hold: inputs toggle with in_valid low; output must not move.
    v8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); op8 = 3'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_out_data8", od8, 8'h0F);
      chk("hold_out_op8", oop8, 0);
    end
    ordy8 = 1'b1;
    send8(3'd2, 8'hAA, 8'hFF);
    drain_all();
    chk("count_after_bp8", cnt8, 11);

    // Randomised operands, ops and downstream readiness.
    rnd8 = 1;
    for (int i = 0; i < 150; i++) send8(3'($urandom), 8'($urandom), 8'($urandom));
    rnd8 = 0;
    drain_all();

    // Asynchronous reset with both entries occupied.
    ordy8 = 1'b0;
    send8(3'd3, 8'h12, 8'h34);
    send8(3'd4, 8'h56, 8'h78);
    chk("pre_reset_full8", r8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid8", ov8, 0);
    chk("async_count8", cnt8, 0);
    chk("async_out_data8", od8, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready8", r8, 1);
    chk("post_reset_out_valid8", ov8, 0);
    ordy8 = 1'b1;
    send8(3'd5, 8'h33, 8'h0F);
    chk("post_reset_data8", od8, 8'hC3);
    drain_all();
    chk("post_reset_count8", cnt8, 1);

    // Exhaustive 1-bit truth table, twice, with random out_ready.
    rnd1 = 1;
    for (int r = 0; r < 2; r++)
      for (int op = 0; op < 8; op++)
        for (int ab = 0; ab < 4; ab++)
          send1(3'(op), ab[1], ab[0]);
    rnd1 = 0;
    drain_all();
    chk("count_wrap1", cnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
